adc_trigger_capture: RTL

Triggered capture stage between the `adc` AXI4-Stream output and the `ccu` ADC input. It buffers ADC samples in a circular memory and waits for a level-crossing, software or external trigger. It then emits exactly one frame of `DEPTH` samples, with a programmable pre-trigger count, as an AXI4-Stream packet terminated by `tlast`. It turns the free-running ADC stream into oscilloscope-style frames for the SPI read path.

---
 rtl/adc_trigger_capture_if.sv | 10 +
 rtl/adc_trigger_capture.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/adc_trigger_capture_if.sv
// AXI4-Stream byte channel between the ADC, the capture stage and the CCU.
interface adc_trigger_capture_if;
  logic       tvalid;
  logic       tready;
  logic [7:0] tdata;
  logic       tlast;

  modport master (output tvalid, output tdata, output tlast, input tready);
  modport slave  (input tvalid, input tdata, input tlast, output tready);
endinterface

// File: rtl/adc_trigger_capture.sv
// Oscilloscope-style triggered capture: circular sample buffer, level/force/external trigger,
// one DEPTH-sample frame out; first beat 2 cycles after READOUT entry, 2-entry output skid.
module adc_trigger_capture #(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8
) (
  input  logic                  axi_aclk,
  input  logic                  axi_areset,
  adc_trigger_capture_if.slave  s_axis,
  adc_trigger_capture_if.master m_axis,
  input  logic                  cfg_arm,
  input  logic                  cfg_abort,
  input  logic                  cfg_force,
  input  logic [7:0]            cfg_level,
  input  logic                  cfg_edge,
  input  logic [ADDR_W-1:0]     cfg_pretrig,
  input  logic                  ext_trig,
  output logic [2:0]            status_state,
  output logic                  status_triggered
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    PRETRIG  = 3'd1,
    ARMED    = 3'd2,
    POSTTRIG = 3'd3,
    READOUT  = 3'd4
  } state_t;

  state_t state, state_nx;

  logic [7:0]        mem [DEPTH];
  logic [ADDR_W-1:0] wp, trig_addr, pre_cnt, pre_nx, pretrig_l, start_addr, rd_addr;
  logic [ADDR_W:0]   post_cnt, post_nx, post_total, rd_cnt;
  logic [7:0]        level_l, prev, ram_q;
  logic              edge_l, prev_valid, force_pend;
  logic [2:0]        ext_sync;
  logic              ext_rise, accept, wr_en, rise, fall, lvl_hit, trig_fire;
  logic              rd_en, rd_pend, rd_last_pend, pop, frame_done;
  logic [1:0]        occ, occ_after;
  logic [7:0]        e0_d, e1_d;
  logic              e0_l, e1_l;
  logic              unused_tlast;

  assign unused_tlast  = s_axis.tlast;
  assign s_axis.tready = !axi_areset && (state != READOUT);
  assign accept        = s_axis.tvalid && s_axis.tready;
  assign wr_en         = accept && (state inside {PRETRIG, ARMED, POSTTRIG});

  assign rise      = prev_valid && (prev < level_l) && (s_axis.tdata >= level_l);
  assign fall      = prev_valid && (prev >= level_l) && (s_axis.tdata < level_l);
  assign lvl_hit   = edge_l ? fall : rise;
  assign trig_fire = (state == ARMED) && accept && !cfg_abort && (force_pend || lvl_hit);
  assign ext_rise  = ext_sync[1] && !ext_sync[2];

  assign pre_nx     = pre_cnt + 1'b1;
  assign post_nx    = post_cnt + 1'b1;
  assign post_total = (ADDR_W+1)'(DEPTH) - {1'b0, pretrig_l};

  // Reads are issued only when the skid is guaranteed room for the returning word.
  assign start_addr = trig_addr - pretrig_l;
  assign rd_addr    = start_addr + rd_cnt[ADDR_W-1:0];
  assign pop        = m_axis.tvalid && m_axis.tready;
  assign occ_after  = occ + {1'b0, rd_pend} - {1'b0, pop};
  assign rd_en      = (state == READOUT) && (rd_cnt != (ADDR_W+1)'(DEPTH)) && (occ_after <= 2'd1);
  assign frame_done = pop && m_axis.tlast;

  assign m_axis.tvalid    = (occ != 2'd0);
  assign m_axis.tdata     = e0_d;
  assign m_axis.tlast     = e0_l;
  assign status_state     = state;
  assign status_triggered = (state == POSTTRIG) || (state == READOUT) || trig_fire;

  always_ff @(posedge axi_aclk or posedge axi_areset) begin
    if (axi_areset) state <= IDLE;
    else            state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:     if (cfg_arm) state_nx = (cfg_pretrig == '0) ? ARMED : PRETRIG;
      PRETRIG:  if (accept && pre_nx == pretrig_l) state_nx = ARMED;
      ARMED:    if (trig_fire) state_nx = (post_total == (ADDR_W+1)'(1)) ? READOUT : POSTTRIG;
      POSTTRIG: if (accept && post_nx == post_total) state_nx = READOUT;
      READOUT:  if (frame_done) state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
    if (cfg_abort && state != READOUT) state_nx = IDLE;
  end

  always_ff @(posedge axi_aclk) begin
    if (wr_en) mem[wp] <= s_axis.tdata;
    if (rd_en) ram_q <= mem[rd_addr];
  end

  always_ff @(posedge axi_aclk or posedge axi_areset) begin
    if (axi_areset) begin
      wp           <= '0;
      trig_addr    <= '0;
      pre_cnt      <= '0;
      post_cnt     <= '0;
      pretrig_l    <= '0;
      level_l      <= '0;
      edge_l       <= 1'b0;
      prev         <= '0;
      prev_valid   <= 1'b0;
      force_pend   <= 1'b0;
      ext_sync     <= '0;
      rd_cnt       <= '0;
      rd_pend      <= 1'b0;
      rd_last_pend <= 1'b0;
      occ          <= '0;
      e0_d         <= '0;
      e1_d         <= '0;
      e0_l         <= 1'b0;
      e1_l         <= 1'b0;
    end else begin
      ext_sync <= {ext_sync[1:0], ext_trig};
      // A pending force only survives while ARMED; anything earlier is discarded.
      force_pend <= (state == ARMED) && !trig_fire && !cfg_abort
                    && (force_pend || cfg_force || ext_rise);
      if (wr_en) wp <= wp + 1'b1;

      if (state == IDLE && cfg_arm) begin
        level_l    <= cfg_level;
        edge_l     <= cfg_edge;
        pretrig_l  <= cfg_pretrig;
        pre_cnt    <= '0;
        post_cnt   <= '0;
        prev_valid <= 1'b0;
      end else if (wr_en) begin
        prev       <= s_axis.tdata;
        prev_valid <= 1'b1;
        if (state == PRETRIG) pre_cnt <= pre_nx;
        if (trig_fire) begin
          trig_addr <= wp;
          post_cnt  <= (ADDR_W+1)'(1);
        end else if (state == POSTTRIG) begin
          post_cnt <= post_nx;
        end
      end

      if (state != READOUT) rd_cnt <= '0;
      else if (rd_en)       rd_cnt <= rd_cnt + 1'b1;
      rd_pend      <= rd_en;
      rd_last_pend <= rd_en && (rd_cnt == (ADDR_W+1)'(DEPTH - 1));

      case ({rd_pend, pop})
        2'b10: begin
          if (occ == 2'd0) begin
            e0_d <= ram_q;
            e0_l <= rd_last_pend;
          end else begin
            e1_d <= ram_q;
            e1_l <= rd_last_pend;
          end
          occ <= occ + 2'd1;
        end
        2'b01: begin
          if (occ == 2'd2) begin
            e0_d <= e1_d;
            e0_l <= e1_l;
          end
          occ <= occ - 2'd1;
        end
        2'b11: begin
          if (occ == 2'd1) begin
            e0_d <= ram_q;
            e0_l <= rd_last_pend;
          end else begin
            e0_d <= e1_d;
            e0_l <= e1_l;
            e1_d <= ram_q;
            e1_l <= rd_last_pend;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
